// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: registered RV32I/E(+M) decode with 2-entry skid buffer and flush
module instruction_decode_stage #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit M_EXTENSION    = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction,
  output logic [2:0]  out_instruction_type,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [4:0]  out_read_index_1,
  output logic [4:0]  out_read_index_2,
  output logic [4:0]  out_write_index,
  output logic [11:0] out_csr_index,
  output logic        out_read_enable_1,
  output logic        out_read_enable_2,
  output logic        out_write_enable,
  output logic        out_read_enable_csr,
  output logic        out_write_enable_csr,
  output logic        out_illegal
);
  localparam logic [2:0] T_INV = 3'd0, T_R = 3'd1, T_I = 3'd2, T_S = 3'd3,
                         T_B = 3'd4, T_U = 3'd5, T_J = 3'd6;
  localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_LOAD_FP = 7'b0000111,
                         OPC_OP_IMM = 7'b0010011, OPC_AUIPC = 7'b0010111,
                         OPC_OP_IMM_32 = 7'b0011011, OPC_STORE = 7'b0100011,
                         OPC_STORE_FP = 7'b0100111, OPC_OP = 7'b0110011,
                         OPC_LUI = 7'b0110111, OPC_OP_FP = 7'b1010011,
                         OPC_BRANCH = 7'b1100011, OPC_JALR = 7'b1100111,
                         OPC_JAL = 7'b1101111, OPC_SYSTEM = 7'b1110011;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  t;
    logic        re1, re2, we, rc, wc, ill;
  } bundle_t;
  bundle_t dec, main_q, skid_q;
  logic main_v, skid_v, acc;
  logic [6:0] op, f7;
  logic [2:0] f3, t;
  logic [4:0] rs1, rs2, rd;
  logic re1, re2, wr, csr_op, cw, narrow_bad, f7_bad, ill;
  assign op  = in_instruction[6:0];
  assign f3  = in_instruction[14:12];
  assign f7  = in_instruction[31:25];
  assign rs1 = in_instruction[19:15];
  assign rs2 = in_instruction[24:20];
  assign rd  = in_instruction[11:7];
  always_comb begin
    t = (op == OPC_OP || op == OPC_OP_FP) ? T_R :
        (op == OPC_LOAD || op == OPC_LOAD_FP || op == OPC_OP_IMM || op == OPC_OP_IMM_32 ||
         op == OPC_JALR || op == OPC_SYSTEM) ? T_I :
        (op == OPC_STORE || op == OPC_STORE_FP) ? T_S :
        (op == OPC_BRANCH) ? T_B :
        (op == OPC_AUIPC || op == OPC_LUI) ? T_U :
        (op == OPC_JAL) ? T_J : T_INV;
    re1 = t inside {T_R, T_I, T_S, T_B};
    re2 = t inside {T_R, T_S, T_B};
    wr = (t inside {T_R, T_I, T_U, T_J}) && rd != 5'd0;
    csr_op = op == OPC_SYSTEM && f3[1:0] != 2'b00;
    // set/clear forms with a zero source/immediate only read the CSR
    cw = csr_op && !(f3[1] && rs1 == 5'd0);
    narrow_bad = REG_ADDR_WIDTH == 4 && ((re1 && rs1[4]) || (re2 && rs2[4]) || (wr && rd[4]));
    f7_bad = op == OPC_OP && !(f7 == 7'h00 || f7 == 7'h20 || (M_EXTENSION && f7 == 7'h01));
    ill = t == T_INV || narrow_bad || f7_bad || (cw && in_instruction[31:30] == 2'b11);
    dec = {in_pc, in_instruction, t, re1, re2, wr && !ill, csr_op, cw && !ill, ill};
  end
  assign in_ready = ~skid_v;
  assign acc = in_valid && !skid_v;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      main_v <= skid_v || acc;
      main_q <= skid_v ? skid_q : acc ? dec : main_q;
      skid_v <= 1'b0;
    end else if (acc) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  assign out_valid            = main_v;
  assign out_pc               = main_q.pc;
  assign out_instruction      = main_q.instr;
  assign out_instruction_type = main_q.t;
  assign out_opcode           = main_q.instr[6:0];
  assign out_funct3           = main_q.instr[14:12];
  assign out_funct7           = main_q.instr[31:25];
  assign out_read_index_1     = main_q.instr[19:15];
  assign out_read_index_2     = main_q.instr[24:20];
  assign out_write_index      = main_q.instr[11:7];
  assign out_csr_index        = main_q.instr[31:20];
  assign out_read_enable_1    = main_q.re1;
  assign out_read_enable_2    = main_q.re2;
  assign out_write_enable     = main_q.we;
  assign out_read_enable_csr  = main_q.rc;
  assign out_write_enable_csr = main_q.wc;
  assign out_illegal          = main_q.ill;
endmodule
